lector_contador_d: RTL and testbench
====================================

Name: lector_contador_d

Overview:
Downstream drain stage of the PCIe QoS path. Pops the D0 and D1 destination FIFOs independently whenever they hold data, and registers each popped word onto per-destination output ports with a valid flag. Keeps per-destination word counters that a requester reads back through a req/idx handshake while the path is idle.

Parameters:
BW, 6, data word width; matches the D0/D1 FIFO width
CW, 5, counter width; also the width of contador_out

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_L  input  1  asynchronous reset, active-low
enable  input  1  drain enable; no pops while low
D0_empty  input  1  D0 FIFO empty flag
D1_empty  input  1  D1 FIFO empty flag
D0_error_output  input  1  D0 FIFO error flag; blocks D0 pops
D1_error_output  input  1  D1 FIFO error flag; blocks D1 pops
D0_data_out  input  BW  D0 FIFO read data, registered-read FIFO
D1_data_out  input  BW  D1 FIFO read data, registered-read FIFO
idle  input  1  idle indication from the main state machine
req  input  1  counter read request, level
idx  input  2  counter select: 0=D0, 1=D1, 2=D0+D1, 3=reserved
D0_rd  output  1  D0 FIFO pop
D1_rd  output  1  D1 FIFO pop
D0_valid  output  1  D0_word holds a new word this cycle
D1_valid  output  1  D1_word holds a new word this cycle
D0_word  output  BW  registered D0 word
D1_word  output  BW  registered D1 word
contador_valid  output  1  one-cycle strobe; contador_out is valid
contador_out  output  CW  selected counter value

Behaviour:
- Reset (reset_L=0, asynchronous): every output and internal register goes to 0, FSM goes to CONTANDO, in-flight pipeline words are discarded. D0_rd and D1_rd are forced to 0 while reset_L=0.
- Pop logic is combinational and the same for each side, D0 shown:
  - D0_rd = reset_L & enable & ~D0_empty & ~D0_error_output.
  - Pop is back-to-back capable: D0_rd stays high every cycle the FIFO is non-empty.
- Read pipeline, per side:
  - D0_rd high at edge k sets stage flag s0 at edge k.
  - The FIFO presents the word during cycle k..k+1.
  - At edge k+1, if s0: D0_word <= D0_data_out and D0_valid <= 1; else D0_valid <= 0.
  - Latency is 2 edges from pop to valid. Throughput is 1 word/clk per side. D0 and D1 are fully independent.
- Counters cnt0 and cnt1 (CW bits each):
  - cnt0 increments at the same edge D0_valid is set; cnt1 likewise for D1.
  - Both may increment on the same edge.
  - Default is modulo 2^CW wrap: 31+1 -> 0 for CW=5.
  - Counters are cleared only by reset; reading does not clear them.
- Sum (idx=2): cnt0+cnt1 truncated to CW bits, wrapping. idx=3 returns 0.
- Readout FSM:
  - CONTANDO: if req & idle, go to REPORTE. If req & ~idle, stay; the request is not latched and the requester must hold req.
  - REPORTE, exactly one cycle: contador_out <= selected value, sampled using idx and counters at that edge; contador_valid <= 1. Next state is ESPERA.
  - ESPERA: contador_valid <= 0 and contador_out holds. Return to CONTANDO when req=0. A held req never produces a second strobe.
- Simultaneous events: a pop, a count increment and a report on the same edge are legal. The report returns the pre-increment value.
- If enable or an error flag drops while a word is in stage s0, that word still completes to valid and is counted.

Optional Feature:
CONTADOR_SATURA_EN:
- Defined: cnt0 and cnt1 saturate at 2^CW-1 and stop incrementing. The idx=2 sum saturates at 2^CW-1 instead of wrapping.
- Not defined: modulo wrap as described in Behaviour.

Test Plan:
- Reset: hold reset_L=0 with D0_empty=0 and enable=1 -> D0_rd=0, all outputs 0; release -> D0_rd=1 in the same cycle.
- Pipeline: D1 FIFO holds 6'b01_1111 then 6'b01_1100, D1_rd high for 2 cycles -> D1_valid high for 2 consecutive cycles, starting 2 edges after the first pop, with words 011111 then 011100. D0_valid stays 0.
- Error block: D0 non-empty, D0_error_output=1 -> D0_rd=0 and cnt0 unchanged. Clear the flag -> pops resume.
- Readout: 8 words to D0 and 5 to D1, then idle=1, req=1 held for 4 cycles with idx=2 -> a single contador_valid pulse with contador_out=13. Repeat with idx=1 -> 5; with idx=3 -> 0.
- Not idle: req=1 with idle=0 for 5 cycles -> no strobe. idle rises -> strobe 1 cycle later.
- Wrap: 33 words to D0 -> idx=0 reads 1 by default, 31 with CONTADOR_SATURA_EN.

Source files
------------

// File: rtl/lector_contador_d_if.sv
// lector_contador_d_if: FIFO-side, word output and counter readout signals of the drain stage
interface lector_contador_d_if #(parameter int BW = 6, parameter int CW = 5);
  logic enable, D0_empty, D1_empty, D0_error_output, D1_error_output;
  logic [BW-1:0] D0_data_out, D1_data_out;
  logic idle, req;
  logic [1:0] idx;
  logic D0_rd, D1_rd, D0_valid, D1_valid;
  logic [BW-1:0] D0_word, D1_word;
  logic contador_valid;
  logic [CW-1:0] contador_out;
  modport master (
    output enable, D0_empty, D1_empty, D0_error_output, D1_error_output,
           D0_data_out, D1_data_out, idle, req, idx,
    input  D0_rd, D1_rd, D0_valid, D1_valid, D0_word, D1_word, contador_valid, contador_out
  );
  modport slave (
    input  enable, D0_empty, D1_empty, D0_error_output, D1_error_output,
           D0_data_out, D1_data_out, idle, req, idx,
    output D0_rd, D1_rd, D0_valid, D1_valid, D0_word, D1_word, contador_valid, contador_out
  );
endinterface

// File: rtl/lector_contador_d.sv
// lector_contador_d: drains D0/D1 FIFOs, registers words and counts them per destination.
// CONTADOR_SATURA_EN: counters and the idx=2 sum saturate instead of wrapping.
module lector_contador_d #(
  parameter int BW = 6,
  parameter int CW = 5
) (
  input logic clk,
  input logic reset_L,
  lector_contador_d_if.slave b
);
  typedef enum logic [1:0] {CONTANDO, REPORTE, ESPERA} state_t;
  state_t state, state_d;
  logic s0_0, s0_1, cv_d;
  logic [CW-1:0] cnt0, cnt1, co_d, sel, sum_t;
  logic [CW:0] sum;
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
`ifdef CONTADOR_SATURA_EN
    return (&c) ? c : c + CW'(1);
`else
    return c + CW'(1);
`endif
  endfunction
  assign b.D0_rd = reset_L & b.enable & ~b.D0_empty & ~b.D0_error_output;
  assign b.D1_rd = reset_L & b.enable & ~b.D1_empty & ~b.D1_error_output;
  assign sum = {1'b0, cnt0} + {1'b0, cnt1};
`ifdef CONTADOR_SATURA_EN
  assign sum_t = sum[CW] ? '1 : sum[CW-1:0];
`else
  assign sum_t = sum[CW-1:0];
`endif
  assign sel = (b.idx == 2'd0) ? cnt0 :
               (b.idx == 2'd1) ? cnt1 :
               (b.idx == 2'd2) ? sum_t : '0;
  // A popped word is captured one edge after its pop, when the FIFO's registered read data is valid
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s0_0 <= 1'b0;
      s0_1 <= 1'b0;
      b.D0_valid <= 1'b0;
      b.D1_valid <= 1'b0;
      b.D0_word <= '0;
      b.D1_word <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      s0_0 <= b.D0_rd;
      s0_1 <= b.D1_rd;
      b.D0_valid <= s0_0;
      b.D1_valid <= s0_1;
      if (s0_0) begin
        b.D0_word <= b.D0_data_out;
        cnt0 <= inc(cnt0);
      end
      if (s0_1) begin
        b.D1_word <= b.D1_data_out;
        cnt1 <= inc(cnt1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= CONTANDO;
      b.contador_valid <= 1'b0;
      b.contador_out <= '0;
    end else begin
      state <= state_d;
      b.contador_valid <= cv_d;
      b.contador_out <= co_d;
    end
  end
  // Request is not latched: CONTANDO waits for req and idle together
  always_comb begin
    state_d = state;
    cv_d = 1'b0;
    co_d = b.contador_out;
    case (state)
      CONTANDO: state_d = (b.req & b.idle) ? REPORTE : CONTANDO;
      REPORTE: begin
        state_d = ESPERA;
        cv_d = 1'b1;
        co_d = sel;
      end
      ESPERA: state_d = b.req ? ESPERA : CONTANDO;
      default: state_d = CONTANDO;
    endcase
  end
endmodule

// File: tb/tb_lector_contador_d.sv
// tb_lector_contador_d: scoreboard bench with registered-read FIFO models on D0/D1.
module tb_lector_contador_d;
  localparam int BW = 6;
  localparam int CW = 5;
`ifdef CONTADOR_SATURA_EN
  localparam int WRAP0 = 31;
  localparam int WRAPS = 31;
`else
  localparam int WRAP0 = 10;
  localparam int WRAPS = 15;
`endif
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  lector_contador_d_if #(.BW(BW), .CW(CW)) b();
  lector_contador_d #(.BW(BW), .CW(CW)) dut (.clk(clk), .reset_L(reset_L), .b(b));
  always #5 clk = ~clk;
  logic [BW-1:0] m0 [256];
  logic [BW-1:0] m1 [256];
  logic [7:0] wp0 = 8'd0, wp1 = 8'd0, rp0 = 8'd0, rp1 = 8'd0;
  logic [BW-1:0] q0 [$];
  logic [BW-1:0] q1 [$];
  logic [CW-1:0] qc [$];
  int checks = 0;
  int errors = 0;
  assign b.D0_empty = (rp0 == wp0);
  assign b.D1_empty = (rp1 == wp1);
  always @(posedge clk) begin
    if (b.D0_rd) begin
      b.D0_data_out <= m0[rp0];
      rp0 <= rp0 + 8'd1;
    end
    if (b.D1_rd) begin
      b.D1_data_out <= m1[rp1];
      rp1 <= rp1 + 8'd1;
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic extra(input string n);
    checks++;
    errors++;
    $display("FAIL %s: output valid with nothing expected at %0t", n, $time);
  endtask
  always @(negedge clk) begin
    if (reset_L) begin
      if (b.D0_valid) begin
        if (q0.size() == 0) extra("D0_word");
        else chk("D0_word", b.D0_word, q0.pop_front());
      end
      if (b.D1_valid) begin
        if (q1.size() == 0) extra("D1_word");
        else chk("D1_word", b.D1_word, q1.pop_front());
      end
      if (b.contador_valid) begin
        if (qc.size() == 0) extra("contador_out");
        else chk("contador_out", b.contador_out, qc.pop_front());
      end
    end
  end
  task automatic push0(input logic [BW-1:0] w);
    m0[wp0] = w;
    wp0++;
    q0.push_back(w);
  endtask
  task automatic push1(input logic [BW-1:0] w);
    m1[wp1] = w;
    wp1++;
    q1.push_back(w);
  endtask
  task automatic readout(input logic [1:0] i, input int exp);
    b.idx = i;
    qc.push_back(CW'(exp));
    b.idle = 1'b1;
    b.req = 1'b1;
    repeat (4) @(negedge clk);
    b.req = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("strobe_seen", qc.size(), 0);
  endtask
  initial begin
    b.enable = 1'b1;
    b.D0_error_output = 1'b0;
    b.D1_error_output = 1'b0;
    b.idle = 1'b0;
    b.req = 1'b0;
    b.idx = 2'd0;
    push0(6'h2A);
    repeat (3) @(negedge clk);
    chk("rst_D0_rd", b.D0_rd, 0);
    chk("rst_D1_rd", b.D1_rd, 0);
    chk("rst_D0_valid", b.D0_valid, 0);
    chk("rst_D1_valid", b.D1_valid, 0);
    chk("rst_D0_word", b.D0_word, 0);
    chk("rst_D1_word", b.D1_word, 0);
    chk("rst_cvalid", b.contador_valid, 0);
    chk("rst_cout", b.contador_out, 0);
    reset_L = 1'b1;
    #1 chk("rel_D0_rd", b.D0_rd, 1);
    repeat (5) @(negedge clk);
    push1(6'b011111);
    push1(6'b011100);
    @(posedge clk) #1 chk("d1_lat_e1", b.D1_valid, 0);
    @(posedge clk) #1 chk("d1_lat_e2", b.D1_valid, 1);
    @(posedge clk) #1 chk("d1_lat_e3", b.D1_valid, 1);
    @(posedge clk) #1 chk("d1_lat_e4", b.D1_valid, 0);
    chk("d0_quiet", b.D0_valid, 0);
    @(negedge clk);
    b.D0_error_output = 1'b1;
    m0[wp0] = 6'h15;
    wp0++;
    #1 chk("err_D0_rd", b.D0_rd, 0);
    repeat (3) @(negedge clk);
    chk("err_D0_rd_hold", b.D0_rd, 0);
    readout(2'd0, 1);
    b.D0_error_output = 1'b0;
    q0.push_back(6'h15);
    #1 chk("err_clr_D0_rd", b.D0_rd, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) push0(BW'(6'h30 + i));
    push1(6'h01);
    push1(6'h02);
    push1(6'h03);
    repeat (12) @(negedge clk);
    readout(2'd2, 13);
    readout(2'd1, 5);
    readout(2'd3, 0);
    readout(2'd0, 8);
    b.idle = 1'b0;
    b.req = 1'b1;
    b.idx = 2'd0;
    repeat (5) @(negedge clk);
    qc.push_back(CW'(8));
    b.idle = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("notidle_strobe", qc.size(), 0);
    b.req = 1'b0;
    b.idle = 1'b0;
    repeat (2) @(negedge clk);
    push0(6'h3C);
    @(posedge clk);
    #1 b.enable = 1'b0;
    #1 chk("en_low_D0_rd", b.D0_rd, 0);
    repeat (3) @(negedge clk);
    chk("en_drop_done", q0.size(), 0);
    b.enable = 1'b1;
    for (int i = 0; i < 33; i++) push0(BW'(i));
    repeat (40) @(negedge clk);
    readout(2'd0, WRAP0);
    readout(2'd2, WRAPS);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
